// File: rtl/axi2mem_tcdm_arbiter_if.sv
// Two-lane TCDM command bundle shared by the axi2mem read/write channels and the command queue.
interface axi2mem_tcdm_arbiter_if #(
   parameter int ID_WIDTH   = 6,
   parameter int ADDR_WIDTH = 32
);
   logic                       rd_pend_i;
   logic [1:0]                 rd_req_i;
   logic [1:0][ID_WIDTH-1:0]   rd_id_i;
   logic [1:0][ADDR_WIDTH-1:0] rd_add_i;
   logic [1:0][3:0]            rd_be_i;
   logic [1:0]                 rd_last_i;
   logic [1:0]                 rd_gnt_o;

   logic                       wr_pend_i;
   logic [1:0]                 wr_req_i;
   logic [1:0][ID_WIDTH-1:0]   wr_id_i;
   logic [1:0][ADDR_WIDTH-1:0] wr_add_i;
   logic [1:0][3:0]            wr_be_i;
   logic [1:0]                 wr_last_i;
   logic [1:0][31:0]           wr_wdata_i;
   logic [1:0]                 wr_gnt_o;

   logic [1:0]                 mem_req_o;
   logic                       mem_we_o;
   logic [1:0][ID_WIDTH-1:0]   mem_id_o;
   logic [1:0][ADDR_WIDTH-1:0] mem_add_o;
   logic [1:0][3:0]            mem_be_o;
   logic [1:0]                 mem_last_o;
   logic [1:0][31:0]           mem_wdata_o;
   logic [1:0]                 mem_gnt_i;

   modport slave (
      input  rd_pend_i, rd_req_i, rd_id_i, rd_add_i, rd_be_i, rd_last_i,
      output rd_gnt_o,
      input  wr_pend_i, wr_req_i, wr_id_i, wr_add_i, wr_be_i, wr_last_i, wr_wdata_i,
      output wr_gnt_o,
      output mem_req_o, mem_we_o, mem_id_o, mem_add_o, mem_be_o, mem_last_o, mem_wdata_o,
      input  mem_gnt_i
   );

   modport master (
      output rd_pend_i, rd_req_i, rd_id_i, rd_add_i, rd_be_i, rd_last_i,
      input  rd_gnt_o,
      output wr_pend_i, wr_req_i, wr_id_i, wr_add_i, wr_be_i, wr_last_i, wr_wdata_i,
      input  wr_gnt_o,
      input  mem_req_o, mem_we_o, mem_id_o, mem_add_o, mem_be_o, mem_last_o, mem_wdata_o,
      output mem_gnt_i
   );
endinterface

// File: rtl/axi2mem_tcdm_arbiter.sv
// Burst-locked round-robin arbiter sharing the two-lane TCDM command port between rd and wr channels.
// Optional: AXI2MEM_ARB_FAST_SWITCH_EN hands the port straight to a waiting peer on a last beat.
module axi2mem_tcdm_arbiter #(
   parameter int ID_WIDTH   = 6,
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_BEATS  = 256
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   axi2mem_tcdm_arbiter_if.slave bus,
   output logic [1:0]            owner_o,
   output logic [8:0]            beat_cnt_o,
   output logic                  err_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RD_OWN = 2'b01,
      S_WR_OWN = 2'b10
   } state_t;

   localparam logic [9:0] LP_MAX_BEATS = 10'(MAX_BEATS);

   state_t                     r_state;
   logic                       r_last_wr;
   logic [8:0]                 r_beat_cnt;
   logic                       r_err;

   logic                       w_own_rd;
   logic                       w_own_wr;
   logic                       w_pend;
   logic [1:0]                 w_req;
   logic [1:0]                 w_last;
   logic                       w_partial;
   logic                       w_accept;
   logic                       w_done;
   logic [9:0]                 w_cnt_inc;
   logic [1:0][ID_WIDTH-1:0]   w_id;
   logic [1:0][ADDR_WIDTH-1:0] w_add;
   logic [1:0][3:0]            w_be;
   logic [1:0][31:0]           w_wdata;

   assign w_own_rd = (r_state == S_RD_OWN);
   assign w_own_wr = (r_state == S_WR_OWN);

   // Command mux: the owner's fields go through untouched, everything is zero while idle.
   always_comb begin
      w_req   = '0;
      w_last  = '0;
      w_pend  = 1'b0;
      w_id    = '0;
      w_add   = '0;
      w_be    = '0;
      w_wdata = '0;
      if (w_own_rd) begin
         w_req  = bus.rd_req_i;
         w_last = bus.rd_last_i;
         w_pend = bus.rd_pend_i;
         w_id   = bus.rd_id_i;
         w_add  = bus.rd_add_i;
         w_be   = bus.rd_be_i;
      end else if (w_own_wr) begin
         w_req   = bus.wr_req_i;
         w_last  = bus.wr_last_i;
         w_pend  = bus.wr_pend_i;
         w_id    = bus.wr_id_i;
         w_add   = bus.wr_add_i;
         w_be    = bus.wr_be_i;
         w_wdata = bus.wr_wdata_i;
      end
   end

   assign w_partial = (w_req == 2'b01) || (w_req == 2'b10);
   assign w_accept  = (w_req == 2'b11) && (bus.mem_gnt_i == 2'b11);
   assign w_done    = w_accept && (w_last == 2'b11);
   assign w_cnt_inc = {1'b0, r_beat_cnt} + 10'd1;

`ifdef AXI2MEM_ARB_FAST_SWITCH_EN
   logic w_other_pend;
   assign w_other_pend = w_own_rd ? bus.wr_pend_i : bus.rd_pend_i;
`endif

   // Grants mirror queue availability for the owner only, never the requester's own req.
   assign bus.rd_gnt_o    = w_own_rd ? bus.mem_gnt_i : 2'b00;
   assign bus.wr_gnt_o    = w_own_wr ? bus.mem_gnt_i : 2'b00;
   assign bus.mem_req_o   = w_req & bus.mem_gnt_i;
   assign bus.mem_we_o    = w_own_wr;
   assign bus.mem_id_o    = w_id;
   assign bus.mem_add_o   = w_add;
   assign bus.mem_be_o    = w_be;
   assign bus.mem_last_o  = w_last;
   assign bus.mem_wdata_o = w_wdata;

   assign owner_o    = r_state;
   assign beat_cnt_o = r_beat_cnt;
   assign err_o      = r_err;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_last_wr  <= 1'b1;
         r_beat_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_beat_cnt <= '0;
               if (bus.rd_pend_i && (!bus.wr_pend_i || r_last_wr)) begin
                  r_state <= S_RD_OWN;
               end else if (bus.wr_pend_i) begin
                  r_state <= S_WR_OWN;
               end
            end
            S_RD_OWN, S_WR_OWN: begin
               if (w_partial) begin
                  r_err <= 1'b1;
               end
               if (w_accept) begin
                  if (r_beat_cnt != 9'h1FF) begin
                     r_beat_cnt <= w_cnt_inc[8:0];
                  end
                  if (!w_done && (w_cnt_inc >= LP_MAX_BEATS)) begin
                     r_err <= 1'b1;
                  end
               end
               // The finished burst's length stays visible for the idle cycle that follows.
               if (w_done) begin
                  r_last_wr <= w_own_wr;
`ifdef AXI2MEM_ARB_FAST_SWITCH_EN
                  if (w_other_pend) begin
                     r_state    <= w_own_rd ? S_WR_OWN : S_RD_OWN;
                     r_beat_cnt <= '0;
                  end else begin
                     r_state <= S_IDLE;
                  end
`else
                  r_state <= S_IDLE;
`endif
               end else if (!w_pend) begin
                  r_err     <= 1'b1;
                  r_last_wr <= w_own_wr;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi2mem_tcdm_arbiter.sv
// Self-checking bench for axi2mem_tcdm_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_axi2mem_tcdm_arbiter;
   localparam int IDW  = 6;
   localparam int AW   = 32;
   localparam int MAXB = 256;
`ifdef AXI2MEM_ARB_FAST_SWITCH_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [1:0] owner;
   logic [8:0] beat;
   logic       err;
   int         n_vec = 0;
   int         n_err = 0;

   // reference model state: owner 0 none / 1 rd / 2 wr
   int m_owner, m_cnt, m_err, m_lastwin;

   axi2mem_tcdm_arbiter_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW)) bus ();

   axi2mem_tcdm_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .MAX_BEATS(MAXB)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .bus        (bus),
      .owner_o    (owner),
      .beat_cnt_o (beat),
      .err_o      (err)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_inputs();
      bus.rd_pend_i = 0; bus.rd_req_i = '0; bus.rd_id_i = '0; bus.rd_add_i = '0;
      bus.rd_be_i = '0; bus.rd_last_i = '0;
      bus.wr_pend_i = 0; bus.wr_req_i = '0; bus.wr_id_i = '0; bus.wr_add_i = '0;
      bus.wr_be_i = '0; bus.wr_last_i = '0; bus.wr_wdata_i = '0;
      bus.mem_gnt_i = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_i = 1'b1;
      bus.rd_pend_i = 1; bus.wr_pend_i = 1; bus.mem_gnt_i = 2'b11;
      bus.rd_req_i = 2'b11; bus.rd_add_i[0] = 32'h1234;
      tick(); tick(); #1;
      n_vec++; if (owner !== 2'b00) begin n_err++; $display("FAIL reset_owner: got %b exp 00", owner); end
      n_vec++; if (bus.rd_gnt_o !== 2'b00 || bus.wr_gnt_o !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b/%b exp 00/00", bus.rd_gnt_o, bus.wr_gnt_o); end
      n_vec++; if (bus.mem_req_o !== 2'b00 || bus.mem_we_o !== 1'b0) begin n_err++; $display("FAIL reset_memreq: got %b we %b exp 00 we 0", bus.mem_req_o, bus.mem_we_o); end
      n_vec++; if (bus.mem_add_o !== '0) begin n_err++; $display("FAIL reset_memadd: got %h exp 0", bus.mem_add_o); end
      n_vec++; if (beat !== 9'd0 || err !== 1'b0) begin n_err++; $display("FAIL reset_cnt_err: got %0d/%b exp 0/0", beat, err); end
      rst_i = 1'b0;
      tick(); #1;
      n_vec++; if (owner !== 2'b01 || bus.rd_gnt_o !== 2'b11) begin n_err++; $display("FAIL reset_first_tie: got owner %b rd_gnt %b exp 01/11", owner, bus.rd_gnt_o); end
      do_reset();
   endtask

   task automatic test_rd_burst();
      logic [1:0][AW-1:0] a;
      do_reset();
      bus.rd_pend_i = 1; bus.mem_gnt_i = 2'b11; #1;
      n_vec++; if (bus.rd_gnt_o !== 2'b00 || owner !== 2'b00) begin n_err++; $display("FAIL rd_idle: got gnt %b owner %b exp 00/00", bus.rd_gnt_o, owner); end
      tick();
      for (int b = 1; b <= 4; b++) begin
         a[0] = 32'h1000 + 32'(b * 8); a[1] = a[0] + 32'd4;
         bus.rd_req_i = 2'b11; bus.rd_add_i = a; bus.rd_last_i = (b == 4) ? 2'b11 : 2'b00; #1;
         n_vec++; if (owner !== 2'b01 || bus.rd_gnt_o !== 2'b11) begin n_err++; $display("FAIL rd_own_b%0d: got owner %b gnt %b exp 01/11", b, owner, bus.rd_gnt_o); end
         n_vec++; if (bus.mem_req_o !== 2'b11 || bus.mem_we_o !== 1'b0) begin n_err++; $display("FAIL rd_memreq_b%0d: got %b we %b exp 11 we 0", b, bus.mem_req_o, bus.mem_we_o); end
         n_vec++; if (bus.mem_add_o !== a || bus.mem_last_o !== bus.rd_last_i) begin n_err++; $display("FAIL rd_fields_b%0d: got %h exp %h", b, bus.mem_add_o, a); end
         tick();
         n_vec++; if (beat !== 9'(b)) begin n_err++; $display("FAIL rd_cnt_b%0d: got %0d exp %0d", b, beat, b); end
      end
      bus.rd_pend_i = 0; bus.rd_req_i = '0; bus.rd_last_i = '0; #1;
      n_vec++; if (owner !== 2'b00 || bus.rd_gnt_o !== 2'b00) begin n_err++; $display("FAIL rd_end_owner: got %b gnt %b exp 00/00", owner, bus.rd_gnt_o); end
      tick();
      n_vec++; if (beat !== 9'd0) begin n_err++; $display("FAIL rd_cnt_clear: got %0d exp 0", beat); end
   endtask

   task automatic test_tie();
      do_reset();
      bus.rd_pend_i = 1; bus.wr_pend_i = 1; bus.mem_gnt_i = 2'b11;
      tick();
      n_vec++; if (owner !== 2'b01) begin n_err++; $display("FAIL tie_rd_first: got %b exp 01", owner); end
      bus.rd_req_i = 2'b11; tick();
      bus.rd_last_i = 2'b11; #1;
      n_vec++; if (bus.wr_gnt_o !== 2'b00) begin n_err++; $display("FAIL tie_no_preempt: got wr_gnt %b exp 00", bus.wr_gnt_o); end
      tick();
      bus.rd_pend_i = 0; bus.rd_req_i = '0; bus.rd_last_i = '0; #1;
      n_vec++; if (owner !== (FAST ? 2'b10 : 2'b00)) begin n_err++; $display("FAIL tie_switch1: got %b exp %b", owner, FAST ? 2'b10 : 2'b00); end
      if (!FAST) tick();
      bus.wr_req_i = 2'b11; bus.wr_last_i = 2'b11; bus.rd_pend_i = 1; #1;
      n_vec++; if (owner !== 2'b10 || bus.wr_gnt_o !== 2'b11 || bus.rd_gnt_o !== 2'b00) begin n_err++; $display("FAIL tie_wr_own: got owner %b gnt %b/%b exp 10 11/00", owner, bus.wr_gnt_o, bus.rd_gnt_o); end
      tick();
      bus.wr_req_i = '0; bus.wr_last_i = '0; #1;
      n_vec++; if (owner !== (FAST ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL tie_switch2: got %b exp %b", owner, FAST ? 2'b01 : 2'b00); end
      if (!FAST) tick();
      n_vec++; if (owner !== 2'b01) begin n_err++; $display("FAIL tie_alternate: got %b exp 01", owner); end
      do_reset();
   endtask

   task automatic test_wr_gnt_toggle();
      logic [1:0] gpat [5] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b11};
      int         ecnt [5] = '{1, 1, 2, 2, 3};
      logic [1:0][31:0] wd;
      do_reset();
      bus.wr_pend_i = 1; bus.mem_gnt_i = 2'b11; tick();
      for (int i = 0; i < 5; i++) begin
         wd[0] = $urandom; wd[1] = $urandom;
         bus.wr_req_i = 2'b11; bus.wr_wdata_i = wd; bus.mem_gnt_i = gpat[i];
         bus.wr_last_i = (i == 4) ? 2'b11 : 2'b00; #1;
         n_vec++; if (bus.wr_gnt_o !== gpat[i] || bus.rd_gnt_o !== 2'b00) begin n_err++; $display("FAIL wr_gnt_c%0d: got %b/%b exp %b/00", i, bus.wr_gnt_o, bus.rd_gnt_o, gpat[i]); end
         n_vec++; if (bus.mem_wdata_o !== wd || bus.mem_we_o !== 1'b1 || bus.mem_req_o !== gpat[i]) begin n_err++; $display("FAIL wr_data_c%0d: got %h we %b req %b exp %h 1 %b", i, bus.mem_wdata_o, bus.mem_we_o, bus.mem_req_o, wd, gpat[i]); end
         tick();
         n_vec++; if (beat !== 9'(ecnt[i])) begin n_err++; $display("FAIL wr_cnt_c%0d: got %0d exp %0d", i, beat, ecnt[i]); end
      end
      bus.wr_pend_i = 0; bus.wr_req_i = '0; bus.wr_last_i = '0; #1;
      n_vec++; if (owner !== 2'b00) begin n_err++; $display("FAIL wr_end_owner: got %b exp 00", owner); end
   endtask

   task automatic test_partial();
      do_reset();
      bus.rd_pend_i = 1; bus.mem_gnt_i = 2'b11; tick();
      bus.rd_req_i = 2'b11; tick();
      bus.rd_req_i = 2'b01; #1;
      n_vec++; if (bus.mem_req_o !== 2'b01) begin n_err++; $display("FAIL partial_fwd: got %b exp 01", bus.mem_req_o); end
      tick();
      n_vec++; if (err !== 1'b1 || beat !== 9'd1) begin n_err++; $display("FAIL partial_err: got err %b cnt %0d exp 1/1", err, beat); end
      bus.rd_req_i = 2'b11; bus.rd_last_i = 2'b11; tick();
      bus.rd_pend_i = 0; bus.rd_req_i = '0; bus.rd_last_i = '0;
      tick(); tick();
      n_vec++; if (err !== 1'b1 || owner !== 2'b00) begin n_err++; $display("FAIL partial_sticky: got err %b owner %b exp 1/00", err, owner); end
      do_reset(); #1;
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL partial_clear: got %b exp 0", err); end
   endtask

   task automatic test_pend_drop();
      do_reset();
      bus.rd_pend_i = 1; bus.mem_gnt_i = 2'b11; tick();
      bus.wr_pend_i = 1; bus.rd_req_i = 2'b11; tick(); tick();
      bus.rd_pend_i = 0; bus.rd_req_i = '0; #1;
      n_vec++; if (err !== 1'b0 || owner !== 2'b01 || beat !== 9'd2) begin n_err++; $display("FAIL drop_before: got err %b owner %b cnt %0d exp 0/01/2", err, owner, beat); end
      tick();
      n_vec++; if (err !== 1'b1 || owner !== 2'b00 || bus.wr_gnt_o !== 2'b00) begin n_err++; $display("FAIL drop_idle: got err %b owner %b wr_gnt %b exp 1/00/00", err, owner, bus.wr_gnt_o); end
      tick();
      n_vec++; if (owner !== 2'b10 || bus.wr_gnt_o !== 2'b11) begin n_err++; $display("FAIL drop_wr_granted: got owner %b gnt %b exp 10/11", owner, bus.wr_gnt_o); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      bus.wr_pend_i = 1; bus.mem_gnt_i = 2'b11; tick();
      bus.wr_req_i = 2'b11; tick(); tick();
      bus.wr_req_i = 2'b10; tick();
      n_vec++; if (err !== 1'b1 || beat !== 9'd2) begin n_err++; $display("FAIL midrst_pre: got err %b cnt %0d exp 1/2", err, beat); end
      rst_i = 1'b1; tick();
      n_vec++; if (bus.wr_gnt_o !== 2'b00 || bus.mem_req_o !== 2'b00 || owner !== 2'b00 || beat !== 9'd0 || err !== 1'b0) begin
         n_err++; $display("FAIL midrst_post: got gnt %b req %b owner %b cnt %0d err %b exp 00 00 00 0 0", bus.wr_gnt_o, bus.mem_req_o, owner, beat, err);
      end
      rst_i = 1'b0;
   endtask

   task automatic test_overrun();
      do_reset();
      bus.rd_pend_i = 1; bus.mem_gnt_i = 2'b11; tick();
      bus.rd_req_i = 2'b11;
      for (int i = 0; i < MAXB - 1; i++) tick();
      n_vec++; if (err !== 1'b0 || beat !== 9'(MAXB - 1)) begin n_err++; $display("FAIL ovr_below: got err %b cnt %0d exp 0/%0d", err, beat, MAXB - 1); end
      tick();
      n_vec++; if (err !== 1'b1 || beat !== 9'(MAXB)) begin n_err++; $display("FAIL ovr_hit: got err %b cnt %0d exp 1/%0d", err, beat, MAXB); end
      for (int i = 0; i < 270; i++) tick();
      n_vec++; if (beat !== 9'd511 || owner !== 2'b01) begin n_err++; $display("FAIL ovr_saturate: got cnt %0d owner %b exp 511/01", beat, owner); end
      do_reset();
   endtask

   function automatic logic [1:0] rand_req();
      int r = $urandom_range(0, 9);
      return (r < 7) ? 2'b11 : (r == 7) ? 2'b00 : (r == 8) ? 2'b01 : 2'b10;
   endfunction

   task automatic model_step();
      int req, last, pend, opend;
      if (rst_i) begin m_owner = 0; m_cnt = 0; m_err = 0; m_lastwin = 2; return; end
      if (m_owner == 0) begin
         m_cnt = 0;
         if (bus.rd_pend_i && (!bus.wr_pend_i || m_lastwin == 2)) m_owner = 1;
         else if (bus.wr_pend_i) m_owner = 2;
         return;
      end
      req   = int'(m_owner == 1 ? bus.rd_req_i  : bus.wr_req_i);
      last  = int'(m_owner == 1 ? bus.rd_last_i : bus.wr_last_i);
      pend  = int'(m_owner == 1 ? bus.rd_pend_i : bus.wr_pend_i);
      opend = int'(m_owner == 1 ? bus.wr_pend_i : bus.rd_pend_i);
      if (req == 1 || req == 2) m_err = 1;
      if (req == 3 && bus.mem_gnt_i == 2'b11) begin
         m_cnt = (m_cnt < 511) ? m_cnt + 1 : 511;
         if (last != 3 && m_cnt >= MAXB) m_err = 1;
         if (last == 3) begin
            m_lastwin = m_owner;
            if (FAST && opend != 0) begin m_owner = 3 - m_owner; m_cnt = 0; end
            else m_owner = 0;
            return;
         end
      end
      if (pend == 0) begin m_err = 1; m_lastwin = m_owner; m_owner = 0; end
   endtask

   task automatic test_random();
      logic [1:0]         e_rg, e_wg, e_req;
      logic [1:0][AW-1:0] e_add;
      logic [1:0][31:0]   e_wd;
      do_reset();
      m_owner = 0; m_cnt = 0; m_err = 0; m_lastwin = 2;
      for (int c = 0; c < 1500; c++) begin
         rst_i = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 11) == 0) bus.rd_pend_i = ~bus.rd_pend_i;
         if ($urandom_range(0, 11) == 0) bus.wr_pend_i = ~bus.wr_pend_i;
         bus.rd_req_i = rand_req(); bus.wr_req_i = rand_req();
         bus.rd_last_i = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
         bus.wr_last_i = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
         bus.mem_gnt_i = ($urandom_range(0, 9) < 7) ? 2'b11 : 2'($urandom);
         bus.rd_add_i[0] = $urandom; bus.rd_add_i[1] = bus.rd_add_i[0] + 32'd4;
         bus.wr_add_i[0] = $urandom; bus.wr_add_i[1] = bus.wr_add_i[0] + 32'd4;
         bus.wr_wdata_i[0] = $urandom; bus.wr_wdata_i[1] = $urandom;
         #1;
         e_rg = (m_owner == 1) ? bus.mem_gnt_i : 2'b00;
         e_wg = (m_owner == 2) ? bus.mem_gnt_i : 2'b00;
         e_req = (m_owner == 1) ? (bus.rd_req_i & bus.mem_gnt_i) : (m_owner == 2) ? (bus.wr_req_i & bus.mem_gnt_i) : 2'b00;
         e_add = (m_owner == 1) ? bus.rd_add_i : (m_owner == 2) ? bus.wr_add_i : '0;
         e_wd  = (m_owner == 2) ? bus.wr_wdata_i : '0;
         n_vec++; if (bus.rd_gnt_o !== e_rg || bus.wr_gnt_o !== e_wg) begin n_err++; $display("FAIL rnd_gnt c%0d: got %b/%b exp %b/%b", c, bus.rd_gnt_o, bus.wr_gnt_o, e_rg, e_wg); end
         n_vec++; if (bus.mem_req_o !== e_req || bus.mem_we_o !== (m_owner == 2)) begin n_err++; $display("FAIL rnd_req c%0d: got %b we %b exp %b we %b", c, bus.mem_req_o, bus.mem_we_o, e_req, m_owner == 2); end
         n_vec++; if (bus.mem_add_o !== e_add || bus.mem_wdata_o !== e_wd) begin n_err++; $display("FAIL rnd_fields c%0d: got %h/%h exp %h/%h", c, bus.mem_add_o, bus.mem_wdata_o, e_add, e_wd); end
         n_vec++; if (owner !== 2'(m_owner) || beat !== 9'(m_cnt) || err !== 1'(m_err)) begin n_err++; $display("FAIL rnd_state c%0d: got %b/%0d/%b exp %0d/%0d/%0d", c, owner, beat, err, m_owner, m_cnt, m_err); end
         model_step();
         tick();
      end
      rst_i = 1'b0;
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_rd_burst();
      test_tie();
      test_wr_gnt_toggle();
      test_partial();
      test_pend_drop();
      test_mid_reset();
      test_overrun();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
